// File: rtl/hazard_scoreboard_unit.sv
// rtl/hazard_scoreboard_unit.sv - ID-stage hazard unit with in-flight load scoreboard
// Optional stall/freeze performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module hazard_scoreboard_unit #(
    parameter int REG_ADDR_W = 4,
    parameter int NUM_SRC    = 3,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          forward_enb,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] src_addr,
    input  logic [NUM_SRC-1:0]            src_used,
    input  logic [REG_ADDR_W-1:0]         exe_dest,
    input  logic                          exe_wb_en,
    input  logic                          exe_mem_read,
    input  logic [REG_ADDR_W-1:0]         mem_dest,
    input  logic                          mem_wb_en,
    input  logic                          mem_mem_read,
    input  logic                          sram_ready,
    output logic                          hazard,
    output logic                          freeze,
`ifdef HAZARD_PERF_CNT_EN
    input  logic                          clear_cnt,
    output logic [CNT_W-1:0]              stall_cycles,
    output logic [CNT_W-1:0]              freeze_cycles,
`endif
    output logic                          load_pending
);

    // A load still in MEM is only unforwardable when the SRAM adds latency.
    localparam logic MEM_LOAD_STALLS = (LOAD_LAT > 0);

    function automatic logic src_match(
        input logic [NUM_SRC*REG_ADDR_W-1:0] addrs,
        input logic [NUM_SRC-1:0]            used,
        input logic [REG_ADDR_W-1:0]         dest
    );
        logic m;
        m = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            m = m | (used[i] && (addrs[i*REG_ADDR_W +: REG_ADDR_W] == dest));
        end
        return m;
    endfunction

    logic advance;
    logic exe_hit;
    logic mem_hit;
    logic pend_hit_fwd;

    assign freeze  = ~sram_ready;
    assign advance = ~freeze;
    assign exe_hit = exe_wb_en && src_match(src_addr, src_used, exe_dest);
    assign mem_hit = mem_wb_en && src_match(src_addr, src_used, mem_dest);

    always_comb begin
        hazard = 1'b0;
        if (forward_enb) begin
            hazard = (exe_hit && exe_mem_read)
                   || (MEM_LOAD_STALLS && mem_hit && mem_mem_read)
                   || pend_hit_fwd;
        end else begin
            hazard = exe_hit || mem_hit;
        end
    end

    generate
        if (LOAD_LAT > 0) begin : g_sb
            logic [LOAD_LAT-1:0] vld_q;
            logic [LOAD_LAT-1:0] vld_d;

            always_comb begin
                vld_d = vld_q;
                if (advance) begin
                    vld_d[0] = mem_mem_read && mem_wb_en;
                    for (int k = 1; k < LOAD_LAT; k++) begin
                        vld_d[k] = vld_q[k-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    vld_q <= '0;
                end else begin
                    vld_q <= vld_d;
                end
            end

            assign load_pending = |vld_q;

            // The last slot is forwardable, so its destination is never stored.
            if (LOAD_LAT > 1) begin : g_dest
                logic [REG_ADDR_W-1:0] dest_q [LOAD_LAT-1];
                logic [REG_ADDR_W-1:0] dest_d [LOAD_LAT-1];

                always_comb begin
                    dest_d = dest_q;
                    if (advance) begin
                        dest_d[0] = mem_dest;
                        for (int k = 1; k < LOAD_LAT-1; k++) begin
                            dest_d[k] = dest_q[k-1];
                        end
                    end
                end

                always_ff @(posedge clk) begin
                    dest_q <= dest_d;
                end

                always_comb begin
                    pend_hit_fwd = 1'b0;
                    for (int k = 0; k < LOAD_LAT-1; k++) begin
                        pend_hit_fwd = pend_hit_fwd
                                     | (vld_q[k] && src_match(src_addr, src_used, dest_q[k]));
                    end
                end
            end else begin : g_no_dest
                assign pend_hit_fwd = 1'b0;
            end
        end else begin : g_no_sb
            assign load_pending = 1'b0;
            assign pend_hit_fwd = 1'b0;
        end
    endgenerate

`ifdef HAZARD_PERF_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic [CNT_W-1:0] freeze_cnt_q;
    logic [CNT_W-1:0] freeze_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        freeze_cnt_d = freeze_cnt_q;
        if (clear_cnt) begin
            stall_cnt_d  = '0;
            freeze_cnt_d = '0;
        end else begin
            if (hazard && !freeze && !(&stall_cnt_q)) begin
                stall_cnt_d = stall_cnt_q + CNT_ONE;
            end
            if (freeze && !(&freeze_cnt_q)) begin
                freeze_cnt_d = freeze_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_q  <= '0;
            freeze_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            freeze_cnt_q <= freeze_cnt_d;
        end
    end

    assign stall_cycles  = stall_cnt_q;
    assign freeze_cycles = freeze_cnt_q;
`endif

endmodule

// File: doc/hazard_scoreboard_unit.md
Name: hazard_scoreboard_unit

Overview:
- Parametrised successor hazard unit for the ARM 5-stage pipeline, sitting beside the ID stage.
- Checks up to NUM_SRC ID-stage source operands against EXE/MEM destinations in forwarding and non-forwarding modes.
- Tracks in-flight loads through a LOAD_LAT-deep shift scoreboard, so multi-cycle SRAM load data is stalled on correctly.
- Generates a global freeze from the SRAM ready handshake; optional stall/freeze performance counters.

Parameters:
REG_ADDR_W, 4, register address width
NUM_SRC, 3, number of ID-stage source operands checked (Rn, Rm, Rs)
LOAD_LAT, 1, extra cycles after leaving MEM before load data is forwardable; 0 = classic single load-use stall
CNT_W, 32, performance counter width (optional feature only)

Ports:
clk  in  1  pipeline clock
rst  in  1  synchronous, active-high reset
forward_enb  in  1  1 = forwarding unit active
src_addr  in  NUM_SRC*REG_ADDR_W  packed source addresses, operand i at bits [i*REG_ADDR_W +: REG_ADDR_W]
src_used  in  NUM_SRC  per-operand valid mask
exe_dest  in  REG_ADDR_W  EXE-stage destination
exe_wb_en  in  1  EXE-stage writeback enable
exe_mem_read  in  1  EXE-stage instruction is a load
mem_dest  in  REG_ADDR_W  MEM-stage destination
mem_wb_en  in  1  MEM-stage writeback enable
mem_mem_read  in  1  MEM-stage instruction is a load
sram_ready  in  1  SRAM controller ready; 0 stalls whole pipeline
hazard  out  1  stall PC/IF-ID, insert bubble into EXE
freeze  out  1  global pipeline freeze
load_pending  out  1  any scoreboard slot valid

Behaviour:
- match(d) = OR over i of (src_used[i] && src_addr[i] == d). src_used = 0 never produces a hazard. No register index is special-cased.
- freeze = ~sram_ready, combinational. advance = ~freeze.
- Scoreboard: LOAD_LAT slots {valid, dest}, slot 0 nearest MEM. With LOAD_LAT = 0 there are no slots, pend_hit = 0, and load_pending = 0.
- On each clk edge with advance = 1:
  - slot0 <= {mem_mem_read && mem_wb_en, mem_dest}
  - slot[k] <= slot[k-1]; the last slot's contents are discarded
- advance = 0: all slots hold.
- pend_hit = OR over slots of (valid && match(dest)). load_pending = OR of slot valids.
- forward_enb = 1: hazard = (exe_mem_read && exe_wb_en && match(exe_dest)) || (LOAD_LAT > 0 && mem_mem_read && mem_wb_en && match(mem_dest)) || (LOAD_LAT > 1 && pend_hit over slots 0..LOAD_LAT-2).
  - A load at MEM-exit + LOAD_LAT is forwardable with no stall.
- forward_enb = 0: hazard = (exe_wb_en && match(exe_dest)) || (mem_wb_en && match(mem_dest)). The scoreboard still shifts but does not contribute.
- hazard is combinational and is not gated by freeze; consumers treat freeze as higher priority.
- Reset (rst = 1 at edge): all slot valids cleared, counters zeroed. Takes priority over advance, including mid-load or mid-freeze.
  - After reset: load_pending = 0, freeze follows sram_ready, and hazard depends only on the current EXE/MEM inputs.
- forward_enb toggling mid-operation: the scoreboard keeps tracking, so re-enabling forwarding is immediately correct.
- Simultaneous causes are OR-ed. A load entering slot0 while the last slot expires is legal (pure shift).

Optional Feature:
- Macro HAZARD_PERF_CNT_EN. When defined, adds:
  - clear_cnt  in  1
  - stall_cycles  out  CNT_W
  - freeze_cycles  out  CNT_W
- stall_cycles increments on cycles with hazard = 1 and freeze = 0. freeze_cycles increments on cycles with freeze = 1.
- Both counters saturate at all-ones and reset to 0.
- Priority: rst > clear_cnt (synchronous zero) > increment.
- When undefined, these ports and registers do not exist and behaviour is otherwise identical.

Test Plan:
- Forwarding on, LOAD_LAT = 0: EXE load dest = 3, src_addr op0 = 3, src_used = 001 -> hazard = 1. Same with exe_mem_read = 0 -> hazard = 0.
- Forwarding off: exe_wb_en = 1, exe_dest = 5; mem_wb_en = 1, mem_dest = 7; sources {5, 7} used -> hazard = 1. Clear src_used -> hazard = 0. Mismatched dests -> hazard = 0.
- Scoreboard LOAD_LAT = 2, load dest = 4 leaves MEM:
  - hazard = 1 for src = 4 on the following cycle (slot0 hit).
  - hazard = 0 one cycle later (last slot forwardable).
  - load_pending = 1 for exactly 2 cycles.
- Freeze: sram_ready = 0 for 3 cycles while slot0 holds dest 4 -> slot holds and hazard stays 1. On release it shifts normally; freeze = 1 exactly during sram_ready = 0.
- Reset mid-operation: rst = 1 with slots valid -> next cycle load_pending = 0, hazard = 0 for src = 4.
- HAZARD_PERF_CNT_EN: 5 hazard cycles plus 2 freeze cycles -> stall_cycles = 5, freeze_cycles = 2. clear_cnt -> 0. CNT_W = 4 run for 20 stalls -> saturates at 15.
